// File: rtl/and2_bist_pkg.sv
// ---------------------------------------------------------------------------
// and2_bist_pkg: shared states, vector ROM and golden model for the and2 BIST.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package and2_bist_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    APPLY  = 3'd2,
    CHECK  = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam int         NUM_VEC     = 7;
  localparam logic [2:0] NO_FAIL_IDX = 3'd7;
  localparam logic [2:0] LAST_IDX    = 3'(NUM_VEC - 1);

  // Entry i holds {a, b}; index 0 is the rightmost element.
  localparam logic [NUM_VEC-1:0][1:0] VEC_ROM = {
    2'b11, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b00
  };

  function automatic logic [1:0] vec_at(input logic [2:0] idx);
    if (int'(idx) < NUM_VEC) begin
      return VEC_ROM[idx];
    end
    return 2'b00;
  endfunction

  function automatic logic golden_and(input logic a, input logic b);
    return a & b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/and2_bist_checker_if.sv
// ---------------------------------------------------------------------------
// and2_bist_checker_if: run control, DUT stimulus/response and result bundle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface and2_bist_checker_if #(
  parameter int CNT_W = 4
);

  logic             start;
  logic             dut_a;
  logic             dut_b;
  logic             dut_c;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [2:0]       first_fail_idx;

  // Host/netlist side: requests runs and returns the and2 response.
  modport master (
    output start,
    output dut_c,
    input  dut_a,
    input  dut_b,
    input  busy,
    input  done,
    input  pass,
    input  pass_cnt,
    input  fail_cnt,
    input  first_fail_idx
  );

  // Checker side.
  modport slave (
    input  start,
    input  dut_c,
    output dut_a,
    output dut_b,
    output busy,
    output done,
    output pass,
    output pass_cnt,
    output fail_cnt,
    output first_fail_idx
  );

endinterface

`default_nettype wire

// File: rtl/and2_bist_satcnt.sv
// ---------------------------------------------------------------------------
// and2_bist_satcnt: saturating up-counter with synchronous clear.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module and2_bist_satcnt #(
  parameter int W = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         clr,
  input  wire logic         inc,
  output logic      [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/and2_bist_checker.sv
// ---------------------------------------------------------------------------
// and2_bist_checker: on-fabric and2 truth-table stimulus/response checker.
// Optional AND2_BIST_STOP_ON_FAIL_EN: end the run at the first mismatch. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module and2_bist_checker
  import and2_bist_pkg::*;
#(
  parameter int WARMUP_CYC = 10,
  parameter int SETTLE_CYC = 1,
  parameter int DRAIN_CYC  = 10,
  parameter int CNT_W      = 4
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  and2_bist_checker_if.slave   bus
);

  localparam int MAX_WS  = (WARMUP_CYC > SETTLE_CYC) ? WARMUP_CYC : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_WS > DRAIN_CYC) ? MAX_WS : DRAIN_CYC;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

`ifdef AND2_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [TMR_W-1:0] WARMUP_LOAD = TMR_W'(WARMUP_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] DRAIN_LOAD  = TMR_W'(DRAIN_CYC - 1);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             dut_a_q, dut_a_d;
  logic             dut_b_q, dut_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [2:0]       first_fail_idx_q, first_fail_idx_d;

  logic             cnt_clr;
  logic             pass_inc;
  logic             fail_inc;
  logic             timer_expired;
  logic [1:0]       cur_vec;
  logic [1:0]       nxt_vec;
  logic             match;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  assign timer_expired = (timer_q == '0);
  assign cur_vec       = vec_at(idx_q);
  assign nxt_vec       = vec_at(idx_q + 3'd1);
  assign match         = (bus.dut_c == golden_and(cur_vec[1], cur_vec[0]));

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    timer_d          = timer_expired ? timer_q : (timer_q - 1'b1);
    dut_a_d          = dut_a_q;
    dut_b_d          = dut_b_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    first_fail_idx_d = first_fail_idx_q;
    cnt_clr          = 1'b0;
    pass_inc         = 1'b0;
    fail_inc         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d          = WARMUP;
          timer_d          = WARMUP_LOAD;
          dut_a_d          = 1'b0;
          dut_b_d          = 1'b0;
          busy_d           = 1'b1;
          pass_d           = 1'b0;
          first_fail_idx_d = NO_FAIL_IDX;
          cnt_clr          = 1'b1;
        end
      end

      WARMUP: begin
        if (timer_expired) begin
          state_d            = APPLY;
          idx_d              = 3'd0;
          timer_d            = SETTLE_LOAD;
          {dut_a_d, dut_b_d} = vec_at(3'd0);
        end
      end

      APPLY: begin
        if (timer_expired) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (match) begin
          pass_inc = 1'b1;
        end else begin
          fail_inc = 1'b1;
          if (first_fail_idx_q == NO_FAIL_IDX) begin
            first_fail_idx_d = idx_q;
          end
        end
        // Stimulus for the next vector is registered here so it is stable
        // for the whole following APPLY window.
        if ((idx_q == LAST_IDX) || (STOP_ON_FAIL && !match)) begin
          state_d = DRAIN;
          timer_d = DRAIN_LOAD;
          dut_a_d = 1'b0;
          dut_b_d = 1'b0;
        end else begin
          state_d            = APPLY;
          idx_d              = idx_q + 3'd1;
          timer_d            = SETTLE_LOAD;
          {dut_a_d, dut_b_d} = nxt_vec;
        end
      end

      DRAIN: begin
        if (timer_expired) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (fail_cnt == '0);
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        dut_a_d = 1'b0;
        dut_b_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      idx_q            <= 3'd0;
      timer_q          <= '0;
      dut_a_q          <= 1'b0;
      dut_b_q          <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      first_fail_idx_q <= NO_FAIL_IDX;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      timer_q          <= timer_d;
      dut_a_q          <= dut_a_d;
      dut_b_q          <= dut_b_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      first_fail_idx_q <= first_fail_idx_d;
    end
  end

  and2_bist_satcnt #(
    .W (CNT_W)
  ) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (pass_inc),
    .cnt   (pass_cnt)
  );

  and2_bist_satcnt #(
    .W (CNT_W)
  ) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (fail_inc),
    .cnt   (fail_cnt)
  );

  assign bus.dut_a          = dut_a_q;
  assign bus.dut_b          = dut_b_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.pass_cnt       = pass_cnt;
  assign bus.fail_cnt       = fail_cnt;
  assign bus.first_fail_idx = first_fail_idx_q;

endmodule

`default_nettype wire
